// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO control stage: owns pointers, occupancy, status flags and
// read-valid tracking, and drives both ports of an external dual-port RAM.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BIT   = 9,
    parameter int unsigned ADDR_DEPTH = 512,
    parameter int unsigned AF_LEVEL   = 500,
    parameter int unsigned AE_LEVEL   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic                  wren,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic [ADDR_BIT-1:0]   wraddress,
    output logic                  rden,
    output logic [ADDR_BIT-1:0]   rdaddress,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BIT:0]     usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = ADDR_BIT + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] usedw_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             full_nxt;
    logic             empty_nxt;
    logic             almost_full_nxt;
    logic             almost_empty_nxt;
    logic             overflow_nxt;
    logic             underflow_nxt;

    // A pop frees a slot in the same cycle, so a push at full is still accepted.
    assign rd_acc = rd_req & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);

    assign wren      = wr_acc;
    assign wrdata    = wr_data;
    assign wraddress = wr_ptr[ADDR_BIT-1:0];
    assign rden      = rd_acc;
    assign rdaddress = rd_ptr[ADDR_BIT-1:0];

    // Next-state pointers, occupancy and flags derived from next occupancy.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        usedw_nxt  = usedw;
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw + PTR_W'(1);
            2'b01:   usedw_nxt = usedw - PTR_W'(1);
            default: usedw_nxt = usedw;
        endcase
        full_nxt         = (usedw_nxt == PTR_W'(ADDR_DEPTH));
        empty_nxt        = (usedw_nxt == '0);
        almost_full_nxt  = (usedw_nxt >= PTR_W'(AF_LEVEL));
        almost_empty_nxt = (usedw_nxt <= PTR_W'(AE_LEVEL));
        overflow_nxt     = overflow | (wr_req & ~wr_acc);
        underflow_nxt    = underflow | (rd_req & ~rd_acc);
    end

    // State registers; reset drops contents and any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            usedw        <= usedw_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= almost_full_nxt;
            almost_empty <= almost_empty_nxt;
            rd_valid     <= rd_acc;
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
        end
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO control stage that sits directly upstream of the dual-port RAM and drives both of its ports. It owns the write and read pointers, the occupancy count, the status flags, and read-data-valid tracking. With the RAM it forms the complete synchronous FIFO: the RAM's wrclk and rdclk both tie to clk, and the RAM's rddata is the FIFO's output data.

Parameters:
DATA_WIDTH, 8, data word width; passes through to the RAM and the wrdata path.
ADDR_BIT, 9, RAM address width.
ADDR_DEPTH, 512, FIFO depth in words; must equal 2**ADDR_BIT.
AF_LEVEL, 500, almost_full asserts when usedw >= AF_LEVEL.
AE_LEVEL, 8, almost_empty asserts when usedw <= AE_LEVEL.

Ports:
clk  input  1  single system clock; also drives RAM wrclk/rdclk.
rst_n  input  1  synchronous active-low reset; also drives RAM rst_n.
wr_req  input  1  push request.
wr_data  input  DATA_WIDTH  push data.
rd_req  input  1  pop request.
wren  output  1  to RAM wren.
wrdata  output  DATA_WIDTH  to RAM wrdata.
wraddress  output  ADDR_BIT  to RAM wraddress.
rden  output  1  to RAM rden.
rdaddress  output  ADDR_BIT  to RAM rdaddress.
rd_valid  output  1  RAM rddata holds the popped word this cycle.
full  output  1  usedw == ADDR_DEPTH.
empty  output  1  usedw == 0.
almost_full  output  1  usedw >= AF_LEVEL.
almost_empty  output  1  usedw <= AE_LEVEL.
usedw  output  ADDR_BIT+1  words stored, 0..ADDR_DEPTH.
overflow  output  1  sticky: a push was rejected.
underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on posedge clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, usedw = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Reset mid-operation: the FIFO discards all contents and the pointers restart at 0 on the next edge. Any read in flight is dropped, so rd_valid = 0.
- Pointers: wr_ptr and rd_ptr are ADDR_BIT+1 bits wide and wrap modulo 2*ADDR_DEPTH. Address = ptr[ADDR_BIT-1:0], so the address wraps from ADDR_DEPTH-1 to 0.
- Push acceptance: wr_acc = wr_req & (~full | rd_acc).
- Pop acceptance: rd_acc = rd_req & ~empty.
- RAM drive (combinational):
  - wren = wr_acc, wrdata = wr_data, wraddress = wr_ptr address.
  - rden = rd_acc, rdaddress = rd_ptr address.
- Pointer update: on each accepted push/pop, the matching pointer increments by 1 at the edge.
- usedw update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Flags are registered and computed from the next-state usedw, so they are valid in the same cycle as usedw.
- Read latency: the RAM registers rddata, so rd_valid = registered rd_acc. The data appears one cycle after the accepted pop and holds until the next accepted pop.
- Simultaneous push and pop:
  - When full: both are accepted. The addresses are equal, and the RAM returns the old word because the read samples before the write lands. usedw stays at ADDR_DEPTH and full stays 1.
  - When empty: the pop is rejected and the push is accepted. usedw becomes 1, underflow sets, and there is no write-through forwarding.
- Sticky errors: overflow sets on wr_req & ~wr_acc; underflow sets on rd_req & ~rd_acc. Both clear only on reset.
- A rejected request changes no state other than the sticky error flags.

Test Plan:
- Reset then idle: all outputs at reset values; wren = rden = 0 for 10 cycles.
- Push 0x01..0x05, then pop 5 -> rd_valid one cycle after each rd_acc, RAM data 0x01..0x05 in order; usedw 5 -> 0; empty = 1 after the last pop.
- Push 512 words -> full = 1 and usedw = 512. A 513th push is rejected with overflow = 1 and no wren. almost_full first asserts at usedw = 500.
- At full, push 0xAA with a simultaneous pop -> first word returned, usedw stays 512. Drain 512 -> 0xAA is the last word, confirming address wrap 511 -> 0.
- Pop while empty with a simultaneous push of 0x3C -> underflow = 1, usedw = 1; the next pop returns 0x3C.
- Fill to 20 words, assert rst_n = 0 for 1 cycle during an active pop -> usedw = 0, empty = 1, rd_valid = 0, sticky flags cleared; a fresh push/pop then uses address 0.
